lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Parametrised multi-cycle load/store unit between the core's execute stage and the data-memory port. It replaces same-cycle memory calls with a valid/ready request channel and a separate response channel. It supports byte, halfword, word and (XLEN=64) doubleword accesses with sign/zero extension, write-mask generation and misalignment detection. The core stalls on `req_ready` and consumes one `resp_valid` pulse per accepted request.

## Interface
- `XLEN`, default 32: data width; legal values are 32 and 64.
- `AW`, default 32: byte-address width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  core presents an access.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN=64).
- `req_unsigned`  in  1  zero-extend the load (lbu/lhu/lwu).
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or illegal size.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_wen`  out  1  write request.
- `mem_addr`  out  AW  address aligned to XLEN/8 (low log2(XLEN/8) bits = 0).
- `mem_wdata`  out  XLEN  lane-shifted store data.
- `mem_wmask`  out  XLEN/8  byte-enable mask.
- `mem_resp_valid`  in  1  read data or write acknowledge.
- `mem_rdata`  in  XLEN  full aligned memory word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1. On `req_valid`, latch wen, size, unsigned, addr and wdata.
  - If misaligned (addr mod 2^size ≠ 0) or size=3 with XLEN=32, go to RESP with the error flag set and no memory access.
  - Otherwise go to REQ.
- REQ: `mem_req_valid`=1; address, data and mask are held stable. On `mem_req_ready`, go to WAIT.
- WAIT: on `mem_resp_valid`, capture `mem_rdata` and go to RESP. `mem_resp_valid` is ignored in every other state.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then IDLE.
  - `resp_err` and `resp_rdata` are valid only in this cycle and read 0 otherwise.
- Lane offset is off = addr[log2(XLEN/8)-1:0].
  - `mem_wdata` = wdata << (8·off).
  - `mem_wmask` = ((1<<2^size)−1) << off, masked to XLEN/8 bits.
  - Loads force `mem_wmask`=0.
- Load data: shift `mem_rdata` >> (8·off), truncate to 8·2^size bits, then sign- or zero-extend per `req_unsigned`. A double load ignores `req_unsigned`.
- Stores complete on the memory acknowledge (`mem_resp_valid`); `resp_rdata`=0.
- Reset:
  - Asynchronous; FSM goes to IDLE immediately.
  - All outputs go to 0 except `req_ready`, which is 1.
  - A reset mid-transaction abandons it. A late `mem_resp_valid` after reset is dropped because the FSM is in IDLE.

## Timing
- Request accepted at cycle 0.
- `mem_req_valid` is asserted from cycle 1.
- Minimum load/store latency is 3 cycles (`resp_valid` at cycle 3), with `mem_req_ready`=1 at cycle 1 and `mem_resp_valid` at cycle 2.
- Each memory stall cycle (REQ or WAIT) adds one cycle.
- An error response has a latency of 1 cycle (`resp_valid` at cycle 1).
- Throughput: at most one access per 4 cycles; `req_ready` is low from cycle 1 through the RESP cycle.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to `mem_*`.

## Structure
- Package `lsu_pkg` holds:
  - the `lsu_state_e` enum (IDLE/REQ/WAIT/RESP);
  - the `lsu_size_e` enum (SZ_B/SZ_H/SZ_W/SZ_D);
  - a `size_bytes()` function;
  - a misalignment check function.
- Sub-module `lsu_lane_align` (combinational, parametrised by XLEN) produces the store shift/mask and the load extract/extend. The FSM and latches stay in `lsu_mem_port`.

## Test plan
- XLEN=32, lbu at addr 0x8000_0003, `mem_rdata`=0xA1B2C3D4, with `mem_req_ready`/`mem_resp_valid` asserted immediately:
  - `mem_addr`=0x8000_0000, `mem_wmask`=0;
  - cycle 3: `resp_valid`=1, `resp_rdata`=0x0000_00A1.
- XLEN=32, lh at 0x8000_0002, `mem_rdata`=0x8001_1234 → `resp_rdata`=0xFFFF_8001; the same access with lhu → 0x0000_8001.
- XLEN=32, sb at 0x8000_0001, `req_wdata`=0x0000_00EE → `mem_wdata`=0x0000_EE00, `mem_wmask`=4'b0010, `mem_wen`=1, and `resp_valid` after the acknowledge.
- lw at 0x8000_0002 → `resp_valid` and `resp_err`=1 at cycle 1, with `mem_req_valid` never asserted.
- Backpressure and reset:
  - `mem_req_ready` held low for 5 cycles → `mem_addr`, `mem_wdata` and `mem_wmask` stay stable and `req_ready`=0 throughout.
  - `rst` asserted in WAIT → IDLE at once; a subsequent `mem_resp_valid` produces no `resp_valid`.
- XLEN=64, ld at 0x8000_0008 returns the full `mem_rdata`; sd at 0x8000_0004 gives `resp_err`=1.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// Shared types and helpers for the load/store unit memory port:
// FSM states, access sizes, byte counts and the alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    function automatic logic [3:0] size_bytes(input lsu_size_e sz);
        logic [3:0] nb;
        case (sz)
            SZ_B:    nb = 4'd1;
            SZ_H:    nb = 4'd2;
            SZ_W:    nb = 4'd4;
            SZ_D:    nb = 4'd8;
            default: nb = 4'd1;
        endcase
        return nb;
    endfunction

    // Natural alignment: address must be a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input lsu_size_e sz);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo[1:0];
            SZ_D:    bad = |addr_lo[2:0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core-side request/response channel and data-memory port of the LSU.
// slave = the LSU itself, master = the surrounding core and memory.
interface lsu_mem_port_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    localparam int MW = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [MW-1:0]   mem_wmask;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/lsu_mem_port_lane_align.sv
// Byte-lane steering: store data/mask shifted into the aligned word,
// load data extracted from the aligned word and sign/zero-extended.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int MW   = XLEN / 8,
    localparam int OW   = $clog2(MW)
) (
    input  lsu_size_e       size,
    input  logic            is_unsigned,
    input  logic            wen,
    input  logic [OW-1:0]   off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] store_data,
    output logic [MW-1:0]   store_mask,
    output logic [XLEN-1:0] load_data
);

    logic [OW+2:0]   shamt_s;
    logic [7:0]      base_s;
    logic [MW-1:0]   mask_s;
    logic [XLEN-1:0] ld_shift_s;
    logic [63:0]     ld64_s;
    logic [63:0]     ext_s;
    logic            sgn_s;

    // Lane shift, byte-enable generation and load extension.
    always_comb begin
        shamt_s    = {off, 3'b000};
        store_data = wdata << shamt_s;
        base_s     = 8'((16'd1 << size_bytes(size)) - 16'd1);
        mask_s     = base_s[MW-1:0] << off;
        if (wen) begin
            store_mask = mask_s;
        end else begin
            store_mask = {MW{1'b0}};
        end

        ld_shift_s          = rdata >> shamt_s;
        ld64_s              = {64{1'b0}};
        ld64_s[XLEN-1:0]    = ld_shift_s;
        sgn_s               = 1'b0;
        ext_s               = ld64_s;
        case (size)
            SZ_B: begin
                sgn_s = ~is_unsigned & ld64_s[7];
                ext_s = {{56{sgn_s}}, ld64_s[7:0]};
            end
            SZ_H: begin
                sgn_s = ~is_unsigned & ld64_s[15];
                ext_s = {{48{sgn_s}}, ld64_s[15:0]};
            end
            SZ_W: begin
                sgn_s = ~is_unsigned & ld64_s[31];
                ext_s = {{32{sgn_s}}, ld64_s[31:0]};
            end
            SZ_D: begin
                ext_s = ld64_s;
            end
            default: begin
                ext_s = ld64_s;
            end
        endcase
        load_data = ext_s[XLEN-1:0];
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store unit: latches one core access, issues it on the
// data-memory port and returns a single-cycle response pulse.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input logic          clk,
    input logic          rst,
    lsu_mem_port_if.slave bus
);

    localparam int MW = XLEN / 8;
    localparam int OW = $clog2(MW);

    lsu_state_e      state_r;
    lsu_state_e      state_s;
    lsu_size_e       req_size_s;
    lsu_size_e       size_r;
    logic            wen_r;
    logic            uns_r;
    logic            err_r;
    logic            bad_s;
    logic [AW-1:0]   addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] rdata_r;
    logic [XLEN-1:0] store_data_s;
    logic [MW-1:0]   store_mask_s;
    logic [XLEN-1:0] load_data_s;

    assign req_size_s = lsu_size_e'(bus.req_size);
    assign bad_s      = is_misaligned(bus.req_addr[2:0], req_size_s)
                      | ((XLEN == 32) && (req_size_s == SZ_D));

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bad_s) begin
                        state_s = RESP;
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request latches and response data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_r   <= 1'b0;
            size_r  <= SZ_B;
            uns_r   <= 1'b0;
            addr_r  <= {AW{1'b0}};
            wdata_r <= {XLEN{1'b0}};
            err_r   <= 1'b0;
            rdata_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        wen_r   <= bus.req_wen;
                        size_r  <= req_size_s;
                        uns_r   <= bus.req_unsigned;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        err_r   <= bad_s;
                        rdata_r <= {XLEN{1'b0}};
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        rdata_r <= wen_r ? {XLEN{1'b0}} : load_data_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size        (size_r),
        .is_unsigned (uns_r),
        .wen         (wen_r),
        .off         (addr_r[OW-1:0]),
        .wdata       (wdata_r),
        .rdata       (bus.mem_rdata),
        .store_data  (store_data_s),
        .store_mask  (store_mask_s),
        .load_data   (load_data_s)
    );

    // Every output is a latch or a decode of the state register only.
    assign bus.req_ready     = (state_r == IDLE);
    assign bus.mem_req_valid = (state_r == REQ);
    assign bus.resp_valid    = (state_r == RESP);
    assign bus.resp_err      = (state_r == RESP) & err_r;
    assign bus.resp_rdata    = (state_r == RESP) ? rdata_r : {XLEN{1'b0}};
    assign bus.mem_wen       = wen_r;
    assign bus.mem_addr      = {addr_r[AW-1:OW], {OW{1'b0}}};
    assign bus.mem_wdata     = store_data_s;
    assign bus.mem_wmask     = store_mask_s;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: one XLEN=32 and one XLEN=64 instance,
// hand-computed expectations checked with immediate assertions.
module tb_lsu_mem_port;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   lat;
    logic seen;

    lsu_mem_port_if #(.XLEN(32), .AW(32)) m32 ();
    lsu_mem_port_if #(.XLEN(64), .AW(32)) m64 ();

    lsu_mem_port #(.XLEN(32), .AW(32)) u32 (.clk(clk), .rst(rst), .bus(m32));
    lsu_mem_port #(.XLEN(64), .AW(32)) u64 (.clk(clk), .rst(rst), .bus(m64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input logic rdy, input logic rvld, input logic [63:0] rdata);
        m32.mem_req_ready  = rdy;
        m64.mem_req_ready  = rdy;
        m32.mem_resp_valid = rvld;
        m64.mem_resp_valid = rvld;
        m32.mem_rdata      = rdata[31:0];
        m64.mem_rdata      = rdata;
    endtask

    // Presents one access for a single cycle; returns at the negedge of cycle 1.
    task automatic issue(input bit w64, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [63:0] wdata);
        m32.req_wen      = wen;
        m64.req_wen      = wen;
        m32.req_size     = size;
        m64.req_size     = size;
        m32.req_unsigned = uns;
        m64.req_unsigned = uns;
        m32.req_addr     = addr;
        m64.req_addr     = addr;
        m32.req_wdata    = wdata[31:0];
        m64.req_wdata    = wdata;
        m32.req_valid    = !w64;
        m64.req_valid    = w64;
        @(negedge clk);
        m32.req_valid    = 1'b0;
        m64.req_valid    = 1'b0;
    endtask

    task automatic wait_resp(input bit w64, input int start, output int l);
        bit found;
        logic rv;
        found = 1'b0;
        l = -1;
        for (int i = start; i < start + 30 && !found; i++) begin
            rv = w64 ? m64.resp_valid : m32.resp_valid;
            if (rv) begin
                l = i;
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        m32.req_valid = 1'b0; m32.req_wen = 1'b0; m32.req_size = 2'd0;
        m32.req_unsigned = 1'b0; m32.req_addr = 32'd0; m32.req_wdata = 32'd0;
        m64.req_valid = 1'b0; m64.req_wen = 1'b0; m64.req_size = 2'd0;
        m64.req_unsigned = 1'b0; m64.req_addr = 32'd0; m64.req_wdata = 64'd0;
        set_mem(1'b0, 1'b0, 64'd0);
        repeat (2) @(negedge clk);

        chk("rst_req_ready",   64'(m32.req_ready),     64'd1);
        chk("rst_resp_valid",  64'(m32.resp_valid),    64'd0);
        chk("rst_mem_req_vld", 64'(m32.mem_req_valid), 64'd0);
        chk("rst_mem_addr",    64'(m32.mem_addr),      64'd0);
        chk("rst_mem_wdata",   64'(m32.mem_wdata),     64'd0);
        chk("rst_mem_wmask",   64'(m32.mem_wmask),     64'd0);
        chk("rst_resp_rdata",  64'(m32.resp_rdata),    64'd0);
        chk("rst64_req_ready", 64'(m64.req_ready),     64'd1);
        rst = 1'b0;
        @(negedge clk);

        // lbu 0x8000_0003
        set_mem(1'b1, 1'b1, 64'hA1B2_C3D4);
        issue(1'b0, 1'b0, 2'd0, 1'b1, 32'h8000_0003, 64'd0);
        chk("lbu_mem_req_valid", 64'(m32.mem_req_valid), 64'd1);
        chk("lbu_mem_addr",      64'(m32.mem_addr),      64'h8000_0000);
        chk("lbu_mem_wmask",     64'(m32.mem_wmask),     64'd0);
        chk("lbu_mem_wen",       64'(m32.mem_wen),       64'd0);
        chk("lbu_req_ready",     64'(m32.req_ready),     64'd0);
        wait_resp(1'b0, 1, lat);
        chk("lbu_latency",       64'(lat),               64'd3);
        chk("lbu_rdata",         64'(m32.resp_rdata),    64'h0000_00A1);
        chk("lbu_err",           64'(m32.resp_err),      64'd0);
        @(negedge clk);
        chk("lbu_pulse_end",     64'(m32.resp_valid),    64'd0);
        chk("lbu_rdata_idle",    64'(m32.resp_rdata),    64'd0);
        chk("lbu_ready_again",   64'(m32.req_ready),     64'd1);

        // lh / lhu 0x8000_0002
        set_mem(1'b1, 1'b1, 64'h8001_1234);
        issue(1'b0, 1'b0, 2'd1, 1'b0, 32'h8000_0002, 64'd0);
        wait_resp(1'b0, 1, lat);
        chk("lh_latency", 64'(lat),            64'd3);
        chk("lh_rdata",   64'(m32.resp_rdata), 64'hFFFF_8001);
        @(negedge clk);
        issue(1'b0, 1'b0, 2'd1, 1'b1, 32'h8000_0002, 64'd0);
        wait_resp(1'b0, 1, lat);
        chk("lhu_rdata",  64'(m32.resp_rdata), 64'h0000_8001);
        @(negedge clk);

        // sb 0x8000_0001 with mem_req_ready low for 5 cycles
        set_mem(1'b0, 1'b1, 64'hDEAD_BEEF);
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h8000_0001, 64'h0000_00EE);
        for (int k = 1; k <= 5; k++) begin
            chk("sb_mem_req_valid", 64'(m32.mem_req_valid), 64'd1);
            chk("sb_mem_addr",      64'(m32.mem_addr),      64'h8000_0000);
            chk("sb_mem_wdata",     64'(m32.mem_wdata),     64'h0000_EE00);
            chk("sb_mem_wmask",     64'(m32.mem_wmask),     64'h2);
            chk("sb_mem_wen",       64'(m32.mem_wen),       64'd1);
            chk("sb_req_ready",     64'(m32.req_ready),     64'd0);
            @(negedge clk);
        end
        set_mem(1'b1, 1'b1, 64'hDEAD_BEEF);
        wait_resp(1'b0, 6, lat);
        chk("sb_latency", 64'(lat),            64'd8);
        chk("sb_rdata",   64'(m32.resp_rdata), 64'd0);
        chk("sb_err",     64'(m32.resp_err),   64'd0);
        @(negedge clk);

        // lw 0x8000_0002: misaligned
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'd0);
        chk("lwmis_mem_req_valid", 64'(m32.mem_req_valid), 64'd0);
        wait_resp(1'b0, 1, lat);
        chk("lwmis_latency", 64'(lat),            64'd1);
        chk("lwmis_err",     64'(m32.resp_err),   64'd1);
        chk("lwmis_rdata",   64'(m32.resp_rdata), 64'd0);
        @(negedge clk);
        chk("lwmis_no_mem",   64'(m32.mem_req_valid), 64'd0);
        chk("lwmis_err_idle", 64'(m32.resp_err),      64'd0);
        chk("lwmis_ready",    64'(m32.req_ready),     64'd1);

        // double access on XLEN=32 is illegal even when aligned
        issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h8000_0000, 64'd0);
        wait_resp(1'b0, 1, lat);
        chk("d32_latency", 64'(lat),          64'd1);
        chk("d32_err",     64'(m32.resp_err), 64'd1);
        @(negedge clk);

        // reset while waiting for the memory response
        set_mem(1'b1, 1'b0, 64'h1234_5678);
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'd0);
        @(negedge clk);
        chk("wait_mem_req_valid", 64'(m32.mem_req_valid), 64'd0);
        chk("wait_req_ready",     64'(m32.req_ready),     64'd0);
        rst = 1'b1;
        #1;
        chk("arst_req_ready", 64'(m32.req_ready), 64'd1);
        chk("arst_mem_addr",  64'(m32.mem_addr),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_mem(1'b1, 1'b1, 64'h1234_5678);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | m32.resp_valid;
        end
        chk("late_resp_dropped", 64'(seen), 64'd0);

        // XLEN=64: ld ignores req_unsigned
        set_mem(1'b1, 1'b1, 64'hF123_4567_89AB_CDEF);
        issue(1'b1, 1'b0, 2'd3, 1'b1, 32'h8000_0008, 64'd0);
        chk("ld_mem_addr",  64'(m64.mem_addr),  64'h8000_0008);
        chk("ld_mem_wmask", 64'(m64.mem_wmask), 64'd0);
        wait_resp(1'b1, 1, lat);
        chk("ld_latency", 64'(lat),       64'd3);
        chk("ld_rdata",   m64.resp_rdata, 64'hF123_4567_89AB_CDEF);
        @(negedge clk);

        issue(1'b1, 1'b0, 2'd2, 1'b1, 32'h8000_0004, 64'd0);
        chk("lwu64_mem_addr", 64'(m64.mem_addr), 64'h8000_0000);
        wait_resp(1'b1, 1, lat);
        chk("lwu64_rdata", m64.resp_rdata, 64'h0000_0000_F123_4567);
        @(negedge clk);
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'd0);
        wait_resp(1'b1, 1, lat);
        chk("lw64_rdata",  m64.resp_rdata, 64'hFFFF_FFFF_F123_4567);
        @(negedge clk);

        // sw upper lane on XLEN=64
        issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h8000_0004, 64'h1122_3344);
        chk("sw64_mem_wdata", m64.mem_wdata,       64'h1122_3344_0000_0000);
        chk("sw64_mem_wmask", 64'(m64.mem_wmask),  64'hF0);
        chk("sw64_mem_wen",   64'(m64.mem_wen),    64'd1);
        wait_resp(1'b1, 1, lat);
        chk("sw64_latency", 64'(lat),       64'd3);
        chk("sw64_rdata",   m64.resp_rdata, 64'd0);
        @(negedge clk);

        // sd 0x8000_0004: misaligned double
        issue(1'b1, 1'b1, 2'd3, 1'b0, 32'h8000_0004, 64'h55);
        chk("sdmis_mem_req_valid", 64'(m64.mem_req_valid), 64'd0);
        wait_resp(1'b1, 1, lat);
        chk("sdmis_latency", 64'(lat),          64'd1);
        chk("sdmis_err",     64'(m64.resp_err), 64'd1);
        @(negedge clk);
        chk("sdmis_done", 64'(m64.resp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
